axi_lite_regfile_slave: RTL
===========================

# axi_lite_regfile_slave

- AXI4-Lite slave register file: four 32-bit read/write registers.
- Responder side of the AXI4-Lite master BFM in the block-design bench; answers write and read bursts at offsets 0x0–0xC of the slave window.
- Register contents are exported to user logic.
- Write and read channels run independently, each with one transaction outstanding.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte-address width. Bits [3:2] select the register; bits [1:0] are ignored.

Ports:
- S_AXI_ACLK  in  1  single clock; every flop is on its rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  accepted and ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  accepted and ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- regs_o  out  128  register contents, reg0 in bits [31:0] through reg3 in bits [127:96].

## Operation
- Write FSM states and transitions:
  - W_IDLE: waiting for AW and W.
  - W_HAVE_A: address latched, waiting for data.
  - W_HAVE_D: data latched, waiting for address.
  - W_EXEC: both latched.
  - W_RESP: BVALID high.
- AW and W may arrive in either order or in the same cycle.
  - AW and W in the same cycle: W_IDLE goes directly to W_EXEC.
  - AW first: W_IDLE → W_HAVE_A → W_EXEC.
  - W first: W_IDLE → W_HAVE_D → W_EXEC.
- W_EXEC performs the register write.
  - Each byte lane i whose WSTRB[i] is set is updated; lanes with WSTRB[i]=0 keep their old value.
  - Next state is W_RESP.
- W_RESP → W_IDLE on BVALID && BREADY.
- Read FSM states: R_IDLE (ARREADY high) and R_DATA (RVALID high).
- AR handshake in R_IDLE: RDATA captures the selected register, then R_DATA.
- R_DATA → R_IDLE on RVALID && RREADY.
- RDATA is held stable while RVALID is high.
- Address decode uses addr[3:2] only; every address hits a register. There is no SLVERR.

## Timing
- Reset asserted (asynchronous):
  - reg0–reg3 = 0.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0.
  - RDATA = 0; BRESP = RRESP = 0.
  - Both FSMs go to their IDLE states.
- The READY outputs are registered.
  - They rise on the first edge after ARESETN deasserts.
  - AWREADY is high only in W_IDLE and W_HAVE_D.
  - WREADY is high only in W_IDLE and W_HAVE_A.
  - ARREADY is high only in R_IDLE.
- Write latency:
  - Last of AW/W handshakes at edge k: register updated at edge k+1.
  - BVALID rises at edge k+1, so regs_o reflects the new value in the same cycle BVALID is seen.
- Write throughput: with BREADY held high, BVALID is high for one cycle; AWREADY/WREADY are high again at k+2.
- Read latency: AR handshake at edge k puts RVALID and RDATA valid after edge k. With RREADY high, ARREADY returns after edge k+1.
- Simultaneous read and write to the same register: RDATA returns the value present at the AR handshake edge. A write that commits on that same edge is not visible.
- BREADY/RREADY held low: BVALID/RVALID and data stay high indefinitely, and no new transaction is accepted on that channel.
- Reset asserted mid-transaction: any partially latched AW/W is discarded and no response is issued.

## Structure
- Shared package axi_lite_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the write-FSM and read-FSM state enums;
  - the register count (4).
- Sub-module axi_lite_wstrb_merge: combinational merge of old value, new data and byte strobes. It is instanced once, in the write path.

## Test plan
- Basic write/read sequence:
  - Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to offsets 0x0, 0x4, 0x8, 0xC with WSTRB=0xF.
  - Each write returns BRESP=0; each read-back returns the same value with RRESP=0.
  - regs_o = {0xBEEF0011, 0xDEAD0011, 0xABCD0001, 0x0101FFFF}.
- Byte strobes:
  - With reg1=0xABCD0001, write 0x11223344 to 0x4 with WSTRB=4'b0101.
  - Read of 0x4 returns 0xAB220044.
- Handshake ordering:
  - W presented 3 cycles before AW, then AW presented 3 cycles before W.
  - Both writes land exactly once; BVALID rises one cycle after the later handshake in each case.
- Backpressure:
  - BREADY and RREADY held low for 10 cycles.
  - BVALID, RVALID and RDATA are stable throughout; AWREADY, WREADY and ARREADY stay low until the response handshake.
- Same-cycle collision: AR on 0x8 in the same cycle W_EXEC writes 0x8 with 0x12345678. RDATA returns the old value; a subsequent read returns 0x12345678.
- Reset mid-transaction:
  - Drop ARESETN while in W_HAVE_A.
  - All outputs go to 0 immediately; all registers read 0 after reset, and no stray BVALID appears.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register file slave: response codes,
// FSM state encodings, register geometry and the latched write command.
package axi_lite_pkg;

  localparam int unsigned REG_COUNT = 4;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam int unsigned REG_IDX_W = 2;
  localparam int unsigned ADDR_LSB  = 2;
  localparam int unsigned RESP_W    = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE   = 3'd0,
    W_HAVE_A = 3'd1,
    W_HAVE_D = 3'd2,
    W_EXEC   = 3'd3,
    W_RESP   = 3'd4
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Write command assembled from the AW and W channels.
  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
    logic [STRB_W-1:0]    strb;
  } wr_cmd_t;

endpackage

// File: rtl/axi_lite_wstrb_merge.sv
// Byte-strobe merge: lanes with strb set take new_data, others keep old_data.
// Ports: old_data, new_data (DATA_W), strb (STRB_W) -> merged_c (DATA_W).
module axi_lite_wstrb_merge
  import axi_lite_pkg::*;
(
  input  logic [DATA_W-1:0] old_data,
  input  logic [DATA_W-1:0] new_data,
  input  logic [STRB_W-1:0] strb,
  output logic [DATA_W-1:0] merged_c
);

  always_comb begin
    merged_c = old_data;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) merged_c[i*8 +: 8] = new_data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave with four 32-bit read/write registers exported on regs_o.
// Ports: S_AXI_* AXI4-Lite slave channels (AW, W, B, AR, R) on S_AXI_ACLK with
// async active-low S_AXI_ARESETN; regs_o = {reg3, reg2, reg1, reg0}.
// Write and read channels are independent, one transaction outstanding each.
module axi_lite_regfile_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [REG_COUNT*DATA_W-1:0]     regs_o
);

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic awready_q, awready_d;
  logic wready_q,  wready_d;
  logic bvalid_q,  bvalid_d;
  logic arready_q, arready_d;
  logic rvalid_q,  rvalid_d;
  logic [DATA_W-1:0] rdata_q;
  logic [RESP_W-1:0] bresp_q, rresp_q;

  logic [REG_COUNT-1:0][DATA_W-1:0] regs_q;
  wr_cmd_t           wr_cmd_q;
  logic [DATA_W-1:0] merged_c;
  logic              aw_hs_c, w_hs_c, ar_hs_c, reg_we_c;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_ok_c;
  assign unused_ok_c = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign aw_hs_c = S_AXI_AWVALID && awready_q;
  assign w_hs_c  = S_AXI_WVALID  && wready_q;
  assign ar_hs_c = S_AXI_ARVALID && arready_q;

  // Write FSM state register and registered channel flags.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Write FSM next state; flags are decoded from the next state so they are
  // valid in the same cycle the state is entered.
  always_comb begin
    w_state_d = w_state_q;
    reg_we_c  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) w_state_d = W_EXEC;
        else if (aw_hs_c)      w_state_d = W_HAVE_A;
        else if (w_hs_c)       w_state_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs_c)  w_state_d = W_EXEC;
      W_HAVE_D: if (aw_hs_c) w_state_d = W_EXEC;
      W_EXEC: begin
        reg_we_c  = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP:  if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_D);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Capture address and data halves of the write as each handshake lands.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_cmd_q <= '0;
    end else begin
      if (aw_hs_c) wr_cmd_q.idx <= S_AXI_AWADDR[ADDR_LSB +: REG_IDX_W];
      if (w_hs_c) begin
        wr_cmd_q.data <= DATA_W'(S_AXI_WDATA);
        wr_cmd_q.strb <= STRB_W'(S_AXI_WSTRB);
      end
    end
  end

  axi_lite_wstrb_merge u_wstrb_merge (
    .old_data (regs_q[wr_cmd_q.idx]),
    .new_data (wr_cmd_q.data),
    .strb     (wr_cmd_q.strb),
    .merged_c (merged_c)
  );

  // Register array; a read captured on the commit edge sees the old value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      regs_q <= '0;
    end else if (reg_we_c) begin
      regs_q[wr_cmd_q.idx] <= merged_c;
    end
  end

  // Read FSM state register, flags and data capture.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      if (ar_hs_c) rdata_q <= regs_q[S_AXI_ARADDR[ADDR_LSB +: REG_IDX_W]];
    end
  end

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs_c)      r_state_d = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // Every address decodes to a register, so responses are always OKAY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      bresp_q <= '0;
      rresp_q <= '0;
    end else begin
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(rdata_q);
  assign S_AXI_RRESP   = rresp_q;
  assign regs_o        = regs_q;

endmodule
